// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter control slice.
//   - default PC width and reset value
//   - branch condition encoding (values 5..7 are reserved and never taken)
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT = 32;
    localparam int unsigned PC_RESET_DEFAULT = 0;

    typedef enum logic [2:0] {
        COND_EQ = 3'd0,
        COND_NE = 3'd1,
        COND_LT = 3'd2,
        COND_GE = 3'd3,
        COND_AL = 3'd4
    } cond_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack, circular storage.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the stack)
//   push        : write push_data as the new top; when full, the oldest
//                 entry is overwritten and the count stays at RAS_DEPTH
//   pop         : discard the top entry (ignored when empty)
//   push_data   : address to push
//   top         : current top entry (meaningless when empty)
//   full, empty : occupancy status
module ras_stack #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] prev_idx;
    logic [CNT_W-1:0] count;

    // The slot after the top is either free or, when full, holds the oldest
    // entry, so a push always lands there.
    always_comb begin
        next_idx = (top_idx == IDX_W'(RAS_DEPTH - 1)) ? '0 : top_idx + 1'b1;
        prev_idx = (top_idx == '0) ? IDX_W'(RAS_DEPTH - 1) : top_idx - 1'b1;
    end

    assign full  = (count == CNT_W'(RAS_DEPTH));
    assign empty = (count == '0);
    assign top   = mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_idx <= '0;
            count   <= '0;
        end else if (push) begin
            top_idx <= next_idx;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            top_idx <= prev_idx;
            count   <= count - 1'b1;
        end
    end

    // Storage needs no reset: an empty count hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[next_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_control.sv
// Program-counter control with optional return-address stack.
// Build option: PC_CONTROL_RAS_EN -- when defined, call/ret use an internal
// RAS (ras_stack); otherwise ret jumps to regEnd, call acts as jump and the
// RAS flags are tied low.
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall             : hold pc, RAS and flags this cycle
//   branch, cond      : conditional branch request and condition code
//   zero, neg         : ALU flags used by the condition
//   branchEnd         : branch target
//   jump, jumpEnd     : unconditional jump and its target
//   call, ret, regEnd : subroutine call / return, register return target
//   pc                : registered current PC
//   pcmais            : pc + PC_STEP (wraps)
//   pcProx            : next PC
//   taken             : next PC comes from a redirect, not pcmais
//   ras_ovf, ras_unf  : sticky RAS overflow / underflow
module pc_control
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = PC_WIDTH_DEFAULT,
    parameter int unsigned PC_STEP   = 1,
    parameter int unsigned RESET_PC  = PC_RESET_DEFAULT,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic [2:0]       cond,
    input  logic             zero,
    input  logic             neg,
    input  logic [WIDTH-1:0] branchEnd,
    input  logic             jump,
    input  logic [WIDTH-1:0] jumpEnd,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] regEnd,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcmais,
    output logic [WIDTH-1:0] pcProx,
    output logic             taken,
    output logic             ras_ovf,
    output logic             ras_unf
);

    logic cond_true;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = zero;
            COND_NE: cond_true = !zero;
            COND_LT: cond_true = neg;
            COND_GE: cond_true = !neg;
            COND_AL: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign pcmais = pc + WIDTH'(PC_STEP);

`ifdef PC_CONTROL_RAS_EN
    logic [WIDTH-1:0] ras_top;
    logic             ras_full;
    logic             ras_empty;
    logic             ras_push;
    logic             ras_pop;
    logic             unused_reg_end;

    assign unused_reg_end = ^regEnd;

    // ret wins over call, so a simultaneous call never pushes.
    assign ras_push = call && !ret && !stall;
    assign ras_pop  = ret && !ras_empty && !stall;

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pcmais),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else if (!stall) begin
            if (ras_push && ras_full) begin
                ras_ovf <= 1'b1;
            end
            if (ret && ras_empty) begin
                ras_unf <= 1'b1;
            end
        end
    end
`else
    assign ras_ovf = 1'b0;
    assign ras_unf = 1'b0;
`endif

    always_comb begin
        pcProx = pcmais;
        taken  = 1'b0;
        if (ret) begin
`ifdef PC_CONTROL_RAS_EN
            // Underflowing ret falls through to the sequential path.
            if (!ras_empty) begin
                pcProx = ras_top;
                taken  = 1'b1;
            end
`else
            pcProx = regEnd;
            taken  = 1'b1;
`endif
        end else if (call || jump) begin
            pcProx = jumpEnd;
            taken  = 1'b1;
        end else if (branch && cond_true) begin
            pcProx = branchEnd;
            taken  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= WIDTH'(RESET_PC);
        end else if (!stall) begin
            pc <= pcProx;
        end
    end

endmodule
